instruction_fetch: RTL
======================

// Module: instruction_fetch
// PURPOSE
// - Front of the pipeline; feeds decode_registers through its instruction read port (im_r*).
// - Owns the program counter and issues reads on the instruction memory AR channel.
// - Tracks up to MAX_OUTSTANDING in-flight reads and forwards read data in order to decode.
// - Drops wrong-path responses after a control-transfer redirect.
// PARAMETERS
// - XLEN             32  data/address width
// - RESET_PC         0   first fetch address after reset (bits[1:0] must be 0)
// - MAX_OUTSTANDING  2   max accepted-but-unanswered reads (>=1); also pc FIFO depth
// PORTS
// - clk                 in   1     clock, single domain
// - rstn                in   1     reset, asynchronous, active-low
// - o_im_arvalid        out  1     instruction bus read address valid
// - i_im_arready        in   1     instruction bus read address ready
// - o_im_araddr         out  XLEN  read address, word aligned
// - i_mem_rvalid        in   1     memory read data valid
// - o_mem_rready        out  1     memory read data ready
// - i_mem_rdata         in   XLEN  memory read data
// - i_mem_rresp         in   2     memory read response
// - o_im_rvalid         out  1     to decode: instruction valid
// - i_im_rready         in   1     from decode: instruction ready
// - o_im_rdata          out  XLEN  to decode: instruction
// - o_im_rresp          out  2     to decode: response, passed through unchanged
// - o_ct_pc_valid       out  1     PC of the presented instruction is valid (= o_im_rvalid)
// - o_ct_pc             out  XLEN  PC of the instruction on o_im_rdata
// - i_ct_redirect_valid in   1     control transfer taken (branch/jump), single-cycle pulse
// - i_ct_redirect_pc    in   XLEN  redirect target; bits[1:0] ignored and forced to 0
// BEHAVIOUR
// - Reset (async assert, sync release): pc=RESET_PC; o_im_arvalid=0; o_im_araddr=RESET_PC; FIFO empty.
//   o_im_rvalid, o_mem_rready and o_ct_pc_valid are 0 while rstn=0.
// - AR channel, all outputs registered:
//   - arvalid rises when FIFO count < MAX_OUTSTANDING. The first AR comes 1 cycle after reset release.
//   - arvalid and araddr stay stable until arready.
//   - On handshake: push {stale=ar_stale, addr=araddr} to the FIFO; pc <= pc+4, wrapping mod 2^XLEN.
//   - After a handshake, arvalid stays high next cycle (araddr = new pc) if count after push/pop < MAX.
//     This gives 1 read per cycle at full throughput.
// - Read data path, combinational, in order (head = FIFO head):
//   - drop = head.stale | i_ct_redirect_valid.
//   - o_im_rvalid = i_mem_rvalid & ~drop.
//   - o_mem_rready = ~fifo_empty & (drop | i_im_rready).
//   - o_im_rdata, o_im_rresp = i_mem_rdata, i_mem_rresp.
//   - o_ct_pc = head.addr.
//   - Pop on i_mem_rvalid & o_mem_rready.
//   - i_mem_rvalid with an empty FIFO is a protocol error; never accepted (o_mem_rready=0).
// - Redirect (i_ct_redirect_valid=1):
//   - pc <= {target[XLEN-1:2],2'b00}.
//   - Every FIFO entry is marked stale, including an entry pushed the same cycle.
//   - If arvalid=1 and arready=0: the AR is held with the old address and ar_stale <= 1.
//     On its handshake it is pushed stale and ar_stale clears.
//     The next AR carries the redirect target.
//   - If arvalid=0 or an AR handshake occurs the same cycle: the next AR carries the redirect target.
//   - The response presented in the redirect cycle is dropped (wrong path).
//     Decode flushes its own skid buffer.
//   - Back-to-back redirects: the last one wins; all earlier entries stay stale.
// - rresp != OKAY: forwarded as-is; fetch continues at pc+4 (trap handling is downstream).
// - Simultaneous push and pop with a full FIFO is legal; count is unchanged.
// - Reset mid-operation: all state cleared; responses to pre-reset reads are not tracked.
//   The memory side is reset together with this block.
// STRUCTURE
// - rv32i_pkg (shared):
//   - INSN_BYTES=4
//   - RESP_OKAY=2'b00
//   - typedef fetch_entry_t {logic stale; logic [XLEN-1:0] addr;}
// - Sub-module fetch_pc_fifo:
//   - DEPTH=MAX_OUTSTANDING, push/pop/count/empty/full.
//   - Extra input kill_all sets every stored stale bit and the stale bit of a same-cycle push.
// - Top level: pc register, AR control, ar_stale flag, drop/ready logic.
// TESTING
// - Reset release, i_im_arready=1, memory answers 1 cycle later ->
//   araddr 0,4,8,... on consecutive cycles; o_ct_pc matches each o_im_rdata.
// - MAX_OUTSTANDING=2, memory withholds rvalid ->
//   exactly 2 AR handshakes (0,4); arvalid stays 0 until the first response pops.
// - Reads 0x0,0x4 outstanding, redirect to 0x103 ->
//   both responses consumed with o_im_rvalid=0; next araddr=0x100; o_ct_pc=0x100 on the next delivered instruction.
// - Redirect to 0x40 while araddr=0x8 is held with arready=0 ->
//   0x8 held until arready, its response dropped; next araddr=0x40.
// - i_im_rready=0 with rvalid=1 ->
//   o_mem_rready=0, data and pc held, no pop; rresp=2'b10 beat is forwarded with rresp=2'b10.
// - Assert rstn=0 mid-burst with 2 reads in flight ->
//   arvalid, rvalid and o_mem_rready go 0 immediately; after release the first araddr=RESET_PC.

Source files
------------

// File: rtl/rv32i_pkg.sv
`default_nettype none
// ============================================================================
// Module  : rv32i_pkg
// Purpose : Shared fetch-side constants and types for the rv32i pipeline.
// Contents: XLEN, INSN_BYTES, RESP_OKAY, fetch_entry_t (in-flight read record)
// Revision: 1.0 - initial release
// ============================================================================
package rv32i_pkg;

  localparam int XLEN       = 32;
  localparam int INSN_BYTES = 4;
  localparam logic [1:0] RESP_OKAY = 2'b00;

  // One in-flight instruction read: its address and whether it is wrong-path.
  typedef struct packed {
    logic            stale;
    logic [XLEN-1:0] addr;
  } fetch_entry_t;

endpackage
`default_nettype wire

// File: rtl/fetch_pc_fifo.sv
`default_nettype none
// ============================================================================
// Module  : fetch_pc_fifo
// Purpose : In-order record of accepted instruction reads (pc + stale flag).
// Ports   : clk, rstn          clock / async active-low reset
//           push, push_entry   record a newly accepted read
//           pop                retire the oldest read
//           kill_all           mark every stored entry (and a same-cycle push) stale
//           head               oldest entry
//           count, empty, full occupancy
// Revision: 1.0 - initial release
// ============================================================================
module fetch_pc_fifo
  import rv32i_pkg::*;
#(
  parameter int DEPTH = 2,
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic               clk,
  input  logic               rstn,
  input  logic               push,
  input  fetch_entry_t       push_entry,
  input  logic               pop,
  input  logic               kill_all,
  output fetch_entry_t       head,
  output logic [CNT_W-1:0]   count,
  output logic               empty,
  output logic               full
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  fetch_entry_t     r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0] r_count;
  logic             w_wr;
  logic             w_rd;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign empty = (r_count == '0);
  assign full  = (r_count == CNT_W'(DEPTH));
  assign count = r_count;
  assign head  = r_mem[r_rd_ptr];

  // A push into a full FIFO is only legal when a pop frees the slot the same cycle.
  assign w_wr = push & (~full | pop);
  assign w_rd = pop & ~empty;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (w_wr && (r_wr_ptr == PTR_W'(i))) begin
          r_mem[i].stale <= push_entry.stale | kill_all;
          r_mem[i].addr  <= push_entry.addr;
        end else if (kill_all) begin
          r_mem[i].stale <= 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_wr) r_wr_ptr <= ptr_inc(r_wr_ptr);
      if (w_rd) r_rd_ptr <= ptr_inc(r_rd_ptr);
      if (w_wr && !w_rd)      r_count <= r_count + 1'b1;
      else if (!w_wr && w_rd) r_count <= r_count - 1'b1;
    end
  end

endmodule
`default_nettype wire

// File: rtl/instruction_fetch.sv
`default_nettype none
// ============================================================================
// Module  : instruction_fetch
// Purpose : Pipeline front end. Owns the PC, issues instruction-memory reads
//           (up to MAX_OUTSTANDING in flight), forwards responses in order to
//           decode and discards wrong-path responses after a redirect.
// Ports   : clk, rstn                          clock / async active-low reset
//           o_im_arvalid/i_im_arready/o_im_araddr  instruction read address
//           i_mem_rvalid/o_mem_rready/i_mem_rdata/i_mem_rresp  memory read data
//           o_im_rvalid/i_im_rready/o_im_rdata/o_im_rresp      to decode
//           o_ct_pc_valid/o_ct_pc              PC of the presented instruction
//           i_ct_redirect_valid/i_ct_redirect_pc  taken control transfer
// Revision: 1.0 - initial release
// ============================================================================
module instruction_fetch #(
  parameter int              XLEN            = 32,
  parameter logic [XLEN-1:0] RESET_PC        = '0,
  parameter int              MAX_OUTSTANDING = 2
) (
  input  logic            clk,
  input  logic            rstn,
  output logic            o_im_arvalid,
  input  logic            i_im_arready,
  output logic [XLEN-1:0] o_im_araddr,
  input  logic            i_mem_rvalid,
  output logic            o_mem_rready,
  input  logic [XLEN-1:0] i_mem_rdata,
  input  logic [1:0]      i_mem_rresp,
  output logic            o_im_rvalid,
  input  logic            i_im_rready,
  output logic [XLEN-1:0] o_im_rdata,
  output logic [1:0]      o_im_rresp,
  output logic            o_ct_pc_valid,
  output logic [XLEN-1:0] o_ct_pc,
  input  logic            i_ct_redirect_valid,
  input  logic [XLEN-1:0] i_ct_redirect_pc
);

  import rv32i_pkg::*;

  localparam int CNT_W = $clog2(MAX_OUTSTANDING + 1);

  // r_pc is the address the next newly launched AR will carry.
  logic [XLEN-1:0]  r_pc;
  logic             r_arvalid;
  logic [XLEN-1:0]  r_araddr;
  logic             r_ar_stale;

  logic             w_ar_hs;
  logic             w_push;
  logic             w_pop;
  logic             w_drop;
  logic             w_launch;
  logic [XLEN-1:0]  w_target;
  logic [XLEN-1:0]  w_launch_addr;
  logic [CNT_W:0]   w_cnt_next;
  fetch_entry_t     w_push_entry;
  fetch_entry_t     w_head;
  logic [CNT_W-1:0] w_count;
  logic             w_empty;
  logic             w_full;

  fetch_pc_fifo #(.DEPTH(MAX_OUTSTANDING)) u_pc_fifo (
    .clk        (clk),
    .rstn       (rstn),
    .push       (w_push),
    .push_entry (w_push_entry),
    .pop        (w_pop),
    .kill_all   (i_ct_redirect_valid),
    .head       (w_head),
    .count      (w_count),
    .empty      (w_empty),
    .full       (w_full)
  );

  // ---------------------------------------------------------------- AR side
  assign w_ar_hs      = r_arvalid & i_im_arready;
  assign w_push       = w_ar_hs & (~w_full | w_pop);
  assign w_push_entry = '{stale: r_ar_stale, addr: r_araddr};
  assign w_target     = i_ct_redirect_pc & ~XLEN'(3);

  // Occupancy after this cycle's push/pop decides whether another AR may go out.
  assign w_cnt_next = {1'b0, w_count} + (CNT_W+1)'(w_push) - (CNT_W+1)'(w_pop);

  // A new AR may only start when none is pending on the bus.
  assign w_launch      = (~r_arvalid | w_ar_hs) &
                         (w_cnt_next < (CNT_W+1)'(MAX_OUTSTANDING));
  assign w_launch_addr = i_ct_redirect_valid ? w_target : r_pc;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_pc       <= RESET_PC;
      r_arvalid  <= 1'b0;
      r_araddr   <= RESET_PC;
      r_ar_stale <= 1'b0;
    end else begin
      if (w_launch) begin
        r_arvalid <= 1'b1;
        r_araddr  <= w_launch_addr;
        r_pc      <= w_launch_addr + XLEN'(INSN_BYTES);
      end else begin
        if (w_ar_hs)             r_arvalid <= 1'b0;
        if (i_ct_redirect_valid) r_pc      <= w_target;
      end

      // A redirect cannot retract an AR already on the bus; its response is
      // tagged wrong-path when it is finally accepted.
      if (i_ct_redirect_valid && r_arvalid && !i_im_arready) r_ar_stale <= 1'b1;
      else if (w_ar_hs)                                      r_ar_stale <= 1'b0;
    end
  end

  assign o_im_arvalid = r_arvalid;
  assign o_im_araddr  = r_araddr;

  // -------------------------------------------------------------- read side
  // The response arriving in a redirect cycle is wrong-path even if its entry
  // was pushed before the redirect.
  assign w_drop       = w_head.stale | i_ct_redirect_valid;
  assign o_mem_rready = ~w_empty & (w_drop | i_im_rready);
  assign o_im_rvalid  = i_mem_rvalid & ~w_empty & ~w_drop;
  assign w_pop        = i_mem_rvalid & o_mem_rready;

  assign o_im_rdata    = i_mem_rdata;
  assign o_im_rresp    = i_mem_rresp;
  assign o_ct_pc       = w_head.addr;
  assign o_ct_pc_valid = o_im_rvalid;

endmodule
`default_nettype wire
